sync_fifo_param: RTL and testbench

// - Single-clock FIFO, the same-domain companion of async_fifo. Used where producer
//   and consumer share one clock, so no CDC synchronisers or Gray pointers are needed.
// - Generalises the FIFO family in four ways:
//   - any Depth >= 2, not restricted to a power of two;
//   - an occupancy level output;
//   - programmable almost-full / almost-empty thresholds;
//   - sticky overflow/underflow error flags.
// - Optional first-word-fall-through read mode.
//

---
 rtl/sync_fifo_param.sv | 109 ++++++++++
 tb/tb_sync_fifo_param.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - single-clock FIFO, any depth, level/threshold flags, sticky errors
// Optional first-word-fall-through read path selected by SYNC_FIFO_FWFT_EN.
module sync_fifo_param #(
    parameter  int Width          = 8,
    parameter  int Depth          = 4,
    parameter  int AlmostFullThr  = 3,
    parameter  int AlmostEmptyThr = 1,
    localparam int LevelW         = $clog2(Depth + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr_en,
    input  logic [Width-1:0]  i_wr_data,
    output logic              o_wr_full,
    output logic              o_wr_almost_full,
    input  logic              i_rd_en,
    output logic [Width-1:0]  o_rd_data,
    output logic              o_rd_empty,
    output logic              o_rd_almost_empty,
    output logic [LevelW-1:0] o_level,
    input  logic              i_err_clr,
    output logic              o_overflow,
    output logic              o_underflow
);
    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0]  mem_q [Depth];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LevelW-1:0] level_q, level_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              wr_acc, rd_acc;

    // Explicit compare so non-power-of-two depths wrap at Depth-1.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign o_wr_full         = (level_q == LevelW'(Depth));
    assign o_rd_empty        = (level_q == '0);
    assign o_wr_almost_full  = (level_q >= LevelW'(AlmostFullThr));
    assign o_rd_almost_empty = (level_q <= LevelW'(AlmostEmptyThr));
    assign o_level           = level_q;
    assign o_overflow        = overflow_q;
    assign o_underflow       = underflow_q;

    assign wr_acc = i_wr_en && !o_wr_full;
    assign rd_acc = i_rd_en && !o_rd_empty;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (wr_acc) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (rd_acc) rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({wr_acc, rd_acc})
            2'b10:   level_d = level_q + LevelW'(1);
            2'b01:   level_d = level_q - LevelW'(1);
            default: level_d = level_q;
        endcase
        if (i_err_clr) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (i_wr_en && o_wr_full)  overflow_d  = 1'b1;
            if (i_rd_en && o_rd_empty) underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wr_ptr_q] <= i_wr_data;
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign o_rd_data = o_rd_empty ? '0 : mem_q[rd_ptr_q];
`else
    logic [Width-1:0] rd_data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (rd_acc) begin
            rd_data_q <= mem_q[rd_ptr_q];
        end
    end

    assign o_rd_data = rd_data_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - table-driven bench for sync_fifo_param, Depth 4 and Depth 5
module tb_sync_fifo_param;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0, rd_en = 1'b0, err_clr = 1'b0;
    logic [7:0] wr_data = 8'h00;

    logic       full4, afull4, empty4, aempty4, ovf4, unf4;
    logic [7:0] rdata4;
    logic [2:0] lvl4;
    logic       full5, afull5, empty5, aempty5, ovf5, unf5;
    logic [7:0] rdata5;
    logic [2:0] lvl5;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sync_fifo_param #(.Width(8), .Depth(4), .AlmostFullThr(3), .AlmostEmptyThr(1)) dut4 (
        .clk(clk), .rst(rst),
        .i_wr_en(wr_en), .i_wr_data(wr_data), .o_wr_full(full4), .o_wr_almost_full(afull4),
        .i_rd_en(rd_en), .o_rd_data(rdata4), .o_rd_empty(empty4), .o_rd_almost_empty(aempty4),
        .o_level(lvl4), .i_err_clr(err_clr), .o_overflow(ovf4), .o_underflow(unf4)
    );

    sync_fifo_param #(.Width(8), .Depth(5), .AlmostFullThr(4), .AlmostEmptyThr(1)) dut5 (
        .clk(clk), .rst(rst),
        .i_wr_en(wr_en), .i_wr_data(wr_data), .o_wr_full(full5), .o_wr_almost_full(afull5),
        .i_rd_en(rd_en), .o_rd_data(rdata5), .o_rd_empty(empty5), .o_rd_almost_empty(aempty5),
        .o_level(lvl5), .i_err_clr(err_clr), .o_overflow(ovf5), .o_underflow(unf5)
    );

    // flg = {full, almost_full, empty, almost_empty} after the edge; pop = word consumed this cycle
    typedef struct {
        bit         wr;
        logic [7:0] wd;
        bit         rd;
        bit         clr;
        int         lvl;
        bit [3:0]   flg;
        bit         ovf;
        bit         unf;
        bit         chk;
        logic [7:0] pop;
    } row_t;

    row_t tab4[$];
    row_t tab5[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input bit d5, input bit wr, input logic [7:0] wd, input bit rd, input bit clr,
                       input int lvl, input bit [3:0] flg, input bit ovf, input bit unf,
                       input bit c, input logic [7:0] pop);
        row_t r;
        r = '{wr, wd, rd, clr, lvl, flg, ovf, unf, c, pop};
        if (d5) tab5.push_back(r);
        else    tab4.push_back(r);
    endtask

    task automatic check_state(input string nm, input bit d5, input int lvl, input bit [3:0] flg,
                               input bit ovf, input bit unf);
        chk({nm, " level"}, d5 ? 32'(lvl5) : 32'(lvl4), 32'(lvl));
        chk({nm, " flags"}, d5 ? 32'({full5, afull5, empty5, aempty5}) : 32'({full4, afull4, empty4, aempty4}), 32'(flg));
        chk({nm, " overflow"}, d5 ? 32'(ovf5) : 32'(ovf4), 32'(ovf));
        chk({nm, " underflow"}, d5 ? 32'(unf5) : 32'(unf4), 32'(unf));
    endtask

    // Called at posedge+1; returns at the following posedge+1.
    task automatic apply(input string nm, input bit d5, input row_t r);
        wr_en   = r.wr;
        wr_data = r.wd;
        rd_en   = r.rd;
        err_clr = r.clr;
`ifdef SYNC_FIFO_FWFT_EN
        #1;
        if (r.chk) chk({nm, " data"}, d5 ? 32'(rdata5) : 32'(rdata4), 32'(r.pop));
`endif
        @(posedge clk);
        #1;
        check_state(nm, d5, r.lvl, r.flg, r.ovf, r.unf);
`ifndef SYNC_FIFO_FWFT_EN
        if (r.chk) chk({nm, " data"}, d5 ? 32'(rdata5) : 32'(rdata4), 32'(r.pop));
`endif
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        err_clr = 1'b0;
    endtask

    task automatic do_reset(input string nm);
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_state({nm, " d4"}, 1'b0, 0, 4'b0011, 1'b0, 1'b0);
        check_state({nm, " d5"}, 1'b1, 0, 4'b0011, 1'b0, 1'b0);
        chk({nm, " rdata"}, 32'(rdata4), 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Depth 4: fill, overflow, drain, underflow
        add(0, 1, 8'h11, 0, 0, 1, 4'b0001, 0, 0, 0, 8'h00);
        add(0, 1, 8'h22, 0, 0, 2, 4'b0000, 0, 0, 0, 8'h00);
        add(0, 1, 8'h33, 0, 0, 3, 4'b0100, 0, 0, 0, 8'h00);
        add(0, 1, 8'h44, 0, 0, 4, 4'b1100, 0, 0, 0, 8'h00);
        add(0, 1, 8'h55, 0, 0, 4, 4'b1100, 1, 0, 0, 8'h00);
        add(0, 0, 8'h00, 0, 1, 4, 4'b1100, 0, 0, 0, 8'h00);
        add(0, 0, 8'h00, 1, 0, 3, 4'b0100, 0, 0, 1, 8'h11);
        add(0, 0, 8'h00, 1, 0, 2, 4'b0000, 0, 0, 1, 8'h22);
        add(0, 0, 8'h00, 1, 0, 1, 4'b0001, 0, 0, 1, 8'h33);
        add(0, 0, 8'h00, 1, 0, 0, 4'b0011, 0, 0, 1, 8'h44);
        add(0, 0, 8'h00, 1, 0, 0, 4'b0011, 0, 1, 0, 8'h00);
        add(0, 0, 8'h00, 0, 1, 0, 4'b0011, 0, 0, 0, 8'h00);
        // wr+rd while full, then wr+rd while empty
        add(0, 1, 8'hA1, 0, 0, 1, 4'b0001, 0, 0, 0, 8'h00);
        add(0, 1, 8'hA2, 0, 0, 2, 4'b0000, 0, 0, 0, 8'h00);
        add(0, 1, 8'hA3, 0, 0, 3, 4'b0100, 0, 0, 0, 8'h00);
        add(0, 1, 8'hA4, 0, 0, 4, 4'b1100, 0, 0, 0, 8'h00);
        add(0, 1, 8'hA5, 1, 0, 3, 4'b0100, 1, 0, 1, 8'hA1);
        add(0, 0, 8'h00, 0, 1, 3, 4'b0100, 0, 0, 0, 8'h00);
        add(0, 0, 8'h00, 1, 0, 2, 4'b0000, 0, 0, 1, 8'hA2);
        add(0, 0, 8'h00, 1, 0, 1, 4'b0001, 0, 0, 1, 8'hA3);
        add(0, 0, 8'h00, 1, 0, 0, 4'b0011, 0, 0, 1, 8'hA4);
        add(0, 1, 8'hB1, 1, 0, 1, 4'b0001, 0, 1, 0, 8'h00);
        add(0, 0, 8'h00, 0, 1, 1, 4'b0001, 0, 0, 0, 8'h00);
        add(0, 1, 8'hB2, 0, 0, 2, 4'b0000, 0, 0, 0, 8'h00);
        // ten simultaneous cycles at level 2, pointers wrap repeatedly
        add(0, 1, 8'hC0, 1, 0, 2, 4'b0000, 0, 0, 1, 8'hB1);
        add(0, 1, 8'hC1, 1, 0, 2, 4'b0000, 0, 0, 1, 8'hB2);
        for (int i = 2; i < 10; i++)
            add(0, 1, 8'hC0 + 8'(i), 1, 0, 2, 4'b0000, 0, 0, 1, 8'hC0 + 8'(i - 2));
        add(0, 0, 8'h00, 1, 0, 1, 4'b0001, 0, 0, 1, 8'hC8);
        add(0, 0, 8'h00, 1, 0, 0, 4'b0011, 0, 0, 1, 8'hC9);

        // Depth 5, AlmostFullThr 4: fill, partial drain, 12-cycle wrap, drain
        add(1, 1, 8'h01, 0, 0, 1, 4'b0001, 0, 0, 0, 8'h00);
        add(1, 1, 8'h02, 0, 0, 2, 4'b0000, 0, 0, 0, 8'h00);
        add(1, 1, 8'h03, 0, 0, 3, 4'b0000, 0, 0, 0, 8'h00);
        add(1, 1, 8'h04, 0, 0, 4, 4'b0100, 0, 0, 0, 8'h00);
        add(1, 1, 8'h05, 0, 0, 5, 4'b1100, 0, 0, 0, 8'h00);
        add(1, 1, 8'h06, 0, 0, 5, 4'b1100, 1, 0, 0, 8'h00);
        add(1, 0, 8'h00, 1, 1, 4, 4'b0100, 0, 0, 1, 8'h01);
        add(1, 0, 8'h00, 1, 0, 3, 4'b0000, 0, 0, 1, 8'h02);
        add(1, 0, 8'h00, 1, 0, 2, 4'b0000, 0, 0, 1, 8'h03);
        add(1, 1, 8'h10, 1, 0, 2, 4'b0000, 0, 0, 1, 8'h04);
        add(1, 1, 8'h11, 1, 0, 2, 4'b0000, 0, 0, 1, 8'h05);
        for (int i = 2; i < 12; i++)
            add(1, 1, 8'h10 + 8'(i), 1, 0, 2, 4'b0000, 0, 0, 1, 8'h10 + 8'(i - 2));
        add(1, 0, 8'h00, 1, 0, 1, 4'b0001, 0, 0, 1, 8'h1A);
        add(1, 0, 8'h00, 1, 0, 0, 4'b0011, 0, 0, 1, 8'h1B);

        do_reset("reset4");
        foreach (tab4[i]) apply($sformatf("d4 row%0d", i), 1'b0, tab4[i]);

        // Reset mid-operation at level 3, asserted between edges
        apply("mid wr1", 1'b0, '{1, 8'h61, 0, 0, 1, 4'b0001, 0, 0, 0, 8'h00});
        apply("mid wr2", 1'b0, '{1, 8'h62, 0, 0, 2, 4'b0000, 0, 0, 0, 8'h00});
        apply("mid rd",  1'b0, '{0, 8'h00, 1, 0, 1, 4'b0001, 0, 0, 1, 8'h61});
        apply("mid wr3", 1'b0, '{1, 8'h63, 0, 0, 2, 4'b0000, 0, 0, 0, 8'h00});
        apply("mid wr4", 1'b0, '{1, 8'h64, 0, 0, 3, 4'b0100, 0, 0, 0, 8'h00});
        #3;
        rst = 1'b1;
        #1;
        check_state("mid async", 1'b0, 0, 4'b0011, 1'b0, 1'b0);
        chk("mid async rdata", 32'(rdata4), 32'h0);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        apply("post wr", 1'b0, '{1, 8'h77, 0, 0, 1, 4'b0001, 0, 0, 0, 8'h00});
        apply("post rd", 1'b0, '{0, 8'h00, 1, 0, 0, 4'b0011, 0, 0, 1, 8'h77});

        do_reset("reset5");
        foreach (tab5[i]) apply($sformatf("d5 row%0d", i), 1'b1, tab5[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
